// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter_if                                        |
// | Description : Core-side fetch/data requester ports and memory-side bus   |
// |               of the shared single-port memory arbiter.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  // memory macro
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // pipeline hold
  logic              core_stall;

  // arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, core_stall
  );

  // core + memory view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_en, mem_we, mem_addr, mem_wdata, core_stall
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_port_arbiter                                           |
// | Description : Round-robin arbiter sharing one fixed-latency single-port  |
// |               memory between instruction fetch and load/store ports.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  // counter covers MEM_LAT up to 4 (load value 0..3)
  localparam logic [2:0] c_lat_load = 3'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_gnt_d;      // 1 = current transaction belongs to data port
  logic              r_last_d;     // 1 = data port won the most recent grant
  logic              r_we;         // current transaction is a store
  logic [2:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_valid;
  logic              r_d_valid;

  logic              w_any_req;
  logic              w_grant_d;
  logic              w_take;
  logic              w_capture;
  logic              w_mem_en_nxt;
  logic              w_mem_we_nxt;
  logic              w_if_valid_nxt;
  logic              w_d_valid_nxt;

  // byte offset bits are never used: word accesses only
  wire w_unused = ^{bus.if_addr[1:0], bus.d_addr[1:0]};

  // data wins only when fetch is idle or fetch had the last grant
  assign w_any_req = bus.if_req | bus.d_req;
  assign w_grant_d = bus.d_req & (~bus.if_req | ~r_last_d);
  assign w_take    = (r_state == c_st_idle) & w_any_req;
  assign w_capture = (r_state == c_st_wait) & (r_cnt == 3'd0);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next_state;
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (w_any_req) w_next_state = c_st_issue;
      c_st_issue: w_next_state = r_we ? c_st_resp : c_st_wait;
      c_st_wait:  if (r_cnt == 3'd0) w_next_state = c_st_resp;
      c_st_resp:  w_next_state = c_st_idle;
      default:    w_next_state = c_st_idle;
    endcase
  end

  // output decode: strobes and valids are registered, so decode from next state
  always_comb begin
    w_mem_en_nxt   = (w_next_state == c_st_issue);
    w_mem_we_nxt   = (w_next_state == c_st_issue) & w_grant_d & bus.d_we;
    w_if_valid_nxt = (w_next_state == c_st_resp) & ~r_gnt_d;
    w_d_valid_nxt  = (w_next_state == c_st_resp) &  r_gnt_d;
  end

  // grant bookkeeping, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_d     <= 1'b0;
      r_last_d    <= 1'b1;
      r_we        <= 1'b0;
      r_cnt       <= 3'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
    end else begin
      r_mem_en   <= w_mem_en_nxt;
      r_mem_we   <= w_mem_we_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_d_valid  <= w_d_valid_nxt;

      if (w_take) begin
        r_gnt_d  <= w_grant_d;
        r_last_d <= w_grant_d;
        r_we     <= w_grant_d & bus.d_we;
        if (w_grant_d) begin
          r_mem_addr  <= bus.d_addr[ADDR_W-1:2];
          r_mem_wdata <= bus.d_wdata;
        end else begin
          r_mem_addr  <= bus.if_addr[ADDR_W-1:2];
          r_mem_wdata <= '0;
        end
      end

      if (r_state == c_st_issue) r_cnt <= c_lat_load;
      else if ((r_state == c_st_wait) && (r_cnt != 3'd0)) r_cnt <= r_cnt - 3'd1;

      if (w_capture) begin
        if (r_gnt_d) r_d_rdata  <= bus.mem_rdata;
        else         r_if_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en     = r_mem_en;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.if_valid   = r_if_valid;
  assign bus.d_valid    = r_d_valid;
  assign bus.core_stall = (bus.if_req & ~r_if_valid) | (bus.d_req & ~r_d_valid);

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the core's instruction-fetch port and its load/store data port, so a unified memory can replace separate instruction and data memories.
- Sits between the core (PC/fetch path and the load/store path) and the memory macro.
- Serialises requests with a round-robin FSM and gives the core a stall signal that holds the PC and blocks register write-back until the access completes.

Parameters:
ADDR_W, 32, byte-address width of both requester ports
DATA_W, 32, data word width
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch byte address
if_rdata  out  DATA_W  fetched instruction, registered
if_valid  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, registered
d_valid  out  1  one-cycle completion pulse for a load, or acknowledge for a store
mem_en  out  1  memory access strobe, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W-2  word address = granted addr[ADDR_W-1:2], registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
core_stall  out  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid)

Behaviour:
- Reset values:
  - State IDLE; last_gnt = DATA, so the first conflict grants fetch.
  - mem_en, mem_we, if_valid, d_valid = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Reset is sampled only at a rising clk edge. Reset mid-transaction aborts it: no valid pulse, and outputs return to reset values after that edge.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_gnt, then update last_gnt.
  - On grant, latch addr[ADDR_W-1:2], we (0 for fetch) and wdata into the mem_* registers, go to ISSUE.
  - With no request, stay in IDLE with mem_en = 0.
- ISSUE: mem_en = 1 for exactly one cycle.
  - Store: mem_we = 1; next state RESP.
  - Read: mem_we = 0; load a latency counter with MEM_LAT-1; next state WAIT.
- WAIT:
  - mem_en = 0.
  - Counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into if_rdata or d_rdata (per grant) and go to RESP.
- RESP:
  - Pulse the granted port's valid for one cycle.
  - Requests are ignored this cycle; the requester drops or changes req here.
  - Next state IDLE.
- Latency, measured from the cycle req is first high in IDLE (cycle 0):
  - Read: mem_en at cycle 1, valid at cycle 2+MEM_LAT (cycle 3 for MEM_LAT=1).
  - Store: mem_en/mem_we at cycle 1, d_valid at cycle 2.
- Throughput: a new request is sampled in IDLE on the cycle after RESP; minimum 3 cycles per store, 3+MEM_LAT per read.
- The unserved requester waits with core_stall high; round-robin bounds its wait to one foreign transaction.
- if_rdata/d_rdata hold their value until the next completed read on that port. A store does not change d_rdata.
- Address, we and wdata changes after the grant are ignored.
- Dropping req before valid does not cancel the access: the transaction completes and the valid pulse is still issued.
- addr[1:0] is ignored (word access only). Byte/halfword handling is outside this block.
- mem_en and mem_we are never high outside ISSUE. Only one transaction is in flight at a time.

Test Plan:
- Reset, MEM_LAT=1: hold rst 2 cycles with if_req=1 -> all outputs 0 during reset. After release, mem_en=1 at cycle 2 after the release edge, addr=if_addr>>2.
- Fetch only, MEM_LAT=1, if_addr=0x0000_0010, mem_rdata=0x00500093 -> mem_addr=0x4 at cycle 1, if_valid=1 and if_rdata=0x00500093 at cycle 3, d_valid never set.
- Store, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF. d_valid at cycle 2; core_stall high cycles 0-1, low at cycle 2.
- Simultaneous if_req and d_req (load) after reset -> fetch granted first (if_valid at cycle 3), then the load issues at cycle 5 and d_valid at cycle 7. A second conflict grants data first.
- MEM_LAT=3 load -> valid 5 cycles after req, with mem_rdata captured exactly 3 cycles after the mem_en cycle; mem_en is high for 1 cycle only.
- rst asserted in the WAIT state of a load -> no d_valid, state IDLE. A fresh fetch after reset completes normally with the expected latency.
